// File: rtl/rr_mux_arbiter.sv
// Registered N-way, W-bit multiplexer with per-channel valid/ready handshakes.
// An internal round-robin or fixed-priority arbiter picks one producer per load.
module rr_mux_arbiter #(
   parameter int WIDTH   = 16,
   parameter int N       = 8,
   parameter int RR_MODE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N*WIDTH-1:0]     in_data,
   input  logic [N-1:0]           in_valid,
   output logic [N-1:0]           in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [$clog2(N)-1:0]   out_sel,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int SEL_W = $clog2(N);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] grant_idx;
   logic             any_valid;
   logic             load;
   logic [WIDTH-1:0] chan [N];

   for (genvar k = 0; k < N; k++) begin : g_chan
      assign chan[k] = in_data[k*WIDTH +: WIDTH];
   end

   assign any_valid = |in_valid;
   assign load      = !out_valid || out_ready;

   // Winner search: round-robin starts one past the last grant and wraps,
   // fixed priority scans down so the lowest valid index is written last.
   always_comb begin
      logic             found;
      logic [SEL_W-1:0] cand;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      if (RR_MODE != 0) begin
         for (int i = 1; i <= N; i++) begin
            cand = SEL_W'((int'(ptr) + i) % N);
            if (!found && in_valid[cand]) begin
               grant_idx = cand;
               found     = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            cand = SEL_W'(i);
            if (in_valid[cand]) begin
               grant_idx = cand;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (load && any_valid) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= SEL_W'(N - 1);
      end else if (load) begin
         if (any_valid) begin
            out_valid <= 1'b1;
            out_data  <= chan[grant_idx];
            out_sel   <= grant_idx;
            ptr       <= grant_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are both compared against a queue-free reference model.
module tb_rr_mux_arbiter;

   localparam int W     = 16;
   localparam int N     = 8;
   localparam int SEL_W = $clog2(N);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N*W-1:0]   in_data = '0;
   logic [N-1:0]     in_valid = '0;
   logic             out_ready = 1'b0;

   logic [N-1:0]     rr_in_ready, fp_in_ready;
   logic [W-1:0]     rr_out_data, fp_out_data;
   logic [SEL_W-1:0] rr_out_sel, fp_out_sel;
   logic             rr_out_valid, fp_out_valid;

   int checks = 0;
   int failures = 0;

   // model state, index 0 = round-robin, 1 = fixed priority
   int           mp [2];
   bit           mv [2];
   logic [W-1:0] md [2];
   int           ms [2];

   rr_mux_arbiter #(.WIDTH(W), .N(N), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
      .out_valid(rr_out_valid), .out_ready(out_ready)
   );

   rr_mux_arbiter #(.WIDTH(W), .N(N), .RR_MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
      .out_valid(fp_out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(int m);
      if (m == 0) begin
         for (int o = 1; o <= N; o++) begin
            int c;
            c = (mp[0] + o) % N;
            if (in_valid[c]) return c;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            if (in_valid[c]) return c;
         end
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] dut_ready(int m);
      return (m == 0) ? rr_in_ready : fp_in_ready;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mp[m] = N - 1;
         mv[m] = 1'b0;
         md[m] = '0;
         ms[m] = 0;
      end
   endtask

   task automatic check_outputs();
      chk("rr_out_valid", 32'(rr_out_valid), 32'(mv[0]));
      chk("rr_out_data",  32'(rr_out_data),  32'(md[0]));
      chk("rr_out_sel",   32'(rr_out_sel),   32'(ms[0]));
      chk("fp_out_valid", 32'(fp_out_valid), 32'(mv[1]));
      chk("fp_out_data",  32'(fp_out_data),  32'(md[1]));
      chk("fp_out_sel",   32'(fp_out_sel),   32'(ms[1]));
   endtask

   // Called just after a negedge with inputs already driven.
   task automatic cycle();
      int           w [2];
      bit           ld [2];
      logic [N-1:0] er;
      #1;
      for (int m = 0; m < 2; m++) begin
         w[m]  = winner(m);
         ld[m] = !mv[m] || out_ready;
         er    = (ld[m] && w[m] >= 0) ? (N'(1) << w[m]) : '0;
         chk(m == 0 ? "rr_in_ready" : "fp_in_ready", 32'(dut_ready(m)), 32'(er));
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (ld[m]) begin
            if (w[m] >= 0) begin
               mv[m] = 1'b1;
               md[m] = in_data[w[m]*W +: W];
               ms[m] = w[m];
               mp[m] = w[m];
            end else begin
               mv[m] = 1'b0;
            end
         end
      end
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] held_rr;
      logic [SEL_W-1:0] held_sel;
      model_reset();
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(16'hA000 + k);
      repeat (2) @(negedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      // reset in the middle of traffic
      in_valid  = 8'b0010_1100;
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("pre_reset_valid", 32'(rr_out_valid), 32'd1);
      async_reset();

      // round-robin fairness from ch0
      in_valid = '1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("rr_fair_sel",  32'(rr_out_sel),  32'(k % N));
         chk("rr_fair_data", 32'(rr_out_data), 32'(16'hA000 + (k % N)));
         chk("fp_fair_sel",  32'(fp_out_sel),  32'd0);
      end

      // backpressure
      out_ready = 1'b0;
      held_rr  = rr_out_data;
      held_sel = rr_out_sel;
      repeat (3) begin
         cycle();
         chk("bp_in_ready", 32'(rr_in_ready), 32'd0);
         chk("bp_data",     32'(rr_out_data), 32'(held_rr));
         chk("bp_sel",      32'(rr_out_sel),  32'(held_sel));
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(rr_in_ready), 32'(N'(1) << ((int'(held_sel) + 1) % N)));
      cycle();

      // wrap and skip from ptr=6
      in_valid = 8'b0100_0000;
      cycle();
      chk("wrap_setup_sel", 32'(rr_out_sel), 32'd6);
      in_valid = 8'b0010_0010;
      cycle();
      chk("wrap_sel_ch1", 32'(rr_out_sel), 32'd1);
      cycle();
      chk("wrap_sel_ch5", 32'(rr_out_sel), 32'd5);

      // fixed-priority starvation
      in_valid = 8'b0010_0100;
      repeat (4) begin
         cycle();
         chk("fp_starve_sel", 32'(fp_out_sel), 32'd2);
      end
      in_valid = 8'b0010_0000;
      cycle();
      chk("fp_drop_sel", 32'(fp_out_sel), 32'd5);

      // idle drain
      held_rr  = rr_out_data;
      in_valid = '0;
      cycle();
      chk("idle_valid", 32'(rr_out_valid), 32'd0);
      chk("idle_data",  32'(rr_out_data),  32'(held_rr));
      cycle();

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
         in_valid  = N'($urandom & $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
         if (t == 200) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
